// File: rtl/cva6_tlb_access_ctrl.sv
// Access controller in front of a TLB. Arbitrates instruction and data lookups
// round-robin and passes fill requests straight through. A flush blocks all
// traffic for three cycles: accept, flush pulse, settle. Each granted lookup
// returns one registered response in the following cycle.
module cva6_tlb_access_ctrl #(
   parameter int unsigned ASID_WIDTH = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ireq_valid_i,
   output logic                  ireq_ready_o,
   input  logic [31:0]           ireq_vaddr_i,
   input  logic [ASID_WIDTH-1:0] ireq_asid_i,
   input  logic                  dreq_valid_i,
   output logic                  dreq_ready_o,
   input  logic [31:0]           dreq_vaddr_i,
   input  logic [ASID_WIDTH-1:0] dreq_asid_i,
   output logic                  rsp_valid_o,
   output logic                  rsp_src_o,
   output logic                  rsp_hit_o,
   output logic [31:0]           rsp_content_o,
   output logic                  rsp_is_4M_o,
   input  logic                  upd_valid_i,
   output logic                  upd_ready_o,
   input  logic [62:0]           upd_data_i,
   input  logic                  flush_valid_i,
   output logic                  flush_ready_o,
   input  logic [ASID_WIDTH-1:0] flush_asid_i,
   input  logic [31:0]           flush_vaddr_i,
   output logic                  tlb_lu_access_o,
   output logic [ASID_WIDTH-1:0] tlb_lu_asid_o,
   output logic [31:0]           tlb_lu_vaddr_o,
   input  logic                  tlb_lu_hit_i,
   input  logic [31:0]           tlb_lu_content_i,
   input  logic                  tlb_lu_is_4M_i,
   output logic [62:0]           tlb_update_o,
   output logic                  tlb_flush_o,
   output logic [ASID_WIDTH-1:0] tlb_asid_to_be_flushed_o,
   output logic [31:0]           tlb_vaddr_to_be_flushed_o,
   output logic [15:0]           miss_cnt_o
);

   // state  | meaning
   // IDLE   | lookups and fills accepted; flush accepted with top priority
   // FLUSH  | tlb_flush_o pulse with the captured ASID/vaddr
   // SETTLE | one quiet cycle after the flush before traffic resumes
   typedef enum logic [1:0] {IDLE, FLUSH, SETTLE} state_e;

   state_e                state_q, state_d;
   logic                  rr_last_d_q;   // 1: data side was granted last, so I wins a tie
   logic [ASID_WIDTH-1:0] flush_asid_q;
   logic [31:0]           flush_vaddr_q;
   logic                  rsp_valid_q, rsp_src_q, rsp_hit_q, rsp_is_4M_q;
   logic [31:0]           rsp_content_q;
   logic [15:0]           miss_cnt_q, miss_cnt_d;
   logic                  flush_acc, idle_free, gnt_i, gnt_d;
   logic                  unused_upd_bit;

   assign unused_upd_bit = upd_data_i[62];

   // Flush priority, round-robin lookup arbitration and next-state decode
   always_comb begin
      flush_acc  = (state_q == IDLE) && flush_valid_i;
      idle_free  = (state_q == IDLE) && !flush_valid_i;
      gnt_i      = idle_free && ireq_valid_i && (!dreq_valid_i || rr_last_d_q);
      gnt_d      = idle_free && dreq_valid_i && (!ireq_valid_i || !rr_last_d_q);
      miss_cnt_d = (rsp_valid_q && !rsp_hit_q) ? miss_cnt_q + 16'd1 : miss_cnt_q;
      state_d    = state_q;
      unique case (state_q)
         IDLE:    if (flush_acc) state_d = FLUSH;
         FLUSH:   state_d = SETTLE;
         SETTLE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign flush_ready_o   = flush_acc;
   assign upd_ready_o     = idle_free;
   assign ireq_ready_o    = gnt_i;
   assign dreq_ready_o    = gnt_d;
   assign tlb_lu_access_o = gnt_i || gnt_d;
   assign tlb_lu_vaddr_o  = gnt_i ? ireq_vaddr_i : (gnt_d ? dreq_vaddr_i : 32'd0);
   assign tlb_lu_asid_o   = gnt_i ? ireq_asid_i  : (gnt_d ? dreq_asid_i  : '0);
   assign tlb_update_o    = idle_free ? {upd_valid_i, upd_data_i[61:0]} : 63'd0;

   assign tlb_flush_o               = (state_q == FLUSH);
   assign tlb_asid_to_be_flushed_o  = (state_q == FLUSH) ? flush_asid_q  : '0;
   assign tlb_vaddr_to_be_flushed_o = (state_q == FLUSH) ? flush_vaddr_q : 32'd0;

   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_src_o     = rsp_src_q;
   assign rsp_hit_o     = rsp_hit_q;
   assign rsp_content_o = rsp_content_q;
   assign rsp_is_4M_o   = rsp_is_4M_q;
   assign miss_cnt_o    = miss_cnt_q;

   // State, flush capture, arbitration pointer, response and miss counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         rr_last_d_q   <= 1'b1;
         flush_asid_q  <= '0;
         flush_vaddr_q <= 32'd0;
         rsp_valid_q   <= 1'b0;
         rsp_src_q     <= 1'b0;
         rsp_hit_q     <= 1'b0;
         rsp_content_q <= 32'd0;
         rsp_is_4M_q   <= 1'b0;
         miss_cnt_q    <= 16'd0;
      end else begin
         state_q     <= state_d;
         miss_cnt_q  <= miss_cnt_d;
         rsp_valid_q <= gnt_i || gnt_d;
         if (flush_acc) begin
            flush_asid_q  <= flush_asid_i;
            flush_vaddr_q <= flush_vaddr_i;
         end
         if (gnt_i || gnt_d) begin
            rr_last_d_q   <= gnt_d;
            rsp_src_q     <= gnt_d;
            rsp_hit_q     <= tlb_lu_hit_i;
            rsp_content_q <= tlb_lu_hit_i ? tlb_lu_content_i : 32'd0;
            rsp_is_4M_q   <= tlb_lu_hit_i && tlb_lu_is_4M_i;
         end
      end
   end

endmodule

// File: tb/tb_cva6_tlb_access_ctrl.sv
// Bench for cva6_tlb_access_ctrl: a one-entry fake TLB answers lookups, and a
// behavioural model predicts every output cycle by cycle.
module tb_cva6_tlb_access_ctrl;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        ireq_valid_i = 0, dreq_valid_i = 0, upd_valid_i = 0, flush_valid_i = 0;
   logic [31:0] ireq_vaddr_i = 0, dreq_vaddr_i = 0, flush_vaddr_i = 0;
   logic [0:0]  ireq_asid_i = 0, dreq_asid_i = 0, flush_asid_i = 0;
   logic [62:0] upd_data_i = 0;
   logic        ireq_ready_o, dreq_ready_o, upd_ready_o, flush_ready_o;
   logic        rsp_valid_o, rsp_src_o, rsp_hit_o, rsp_is_4M_o;
   logic [31:0] rsp_content_o;
   logic        tlb_lu_access_o, tlb_lu_hit_i, tlb_lu_is_4M_i, tlb_flush_o;
   logic [0:0]  tlb_lu_asid_o, tlb_asid_to_be_flushed_o;
   logic [31:0] tlb_lu_vaddr_o, tlb_lu_content_i, tlb_vaddr_to_be_flushed_o;
   logic [62:0] tlb_update_o;
   logic [15:0] miss_cnt_o;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   cva6_tlb_access_ctrl #(.ASID_WIDTH(1)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ireq_valid_i(ireq_valid_i), .ireq_ready_o(ireq_ready_o),
      .ireq_vaddr_i(ireq_vaddr_i), .ireq_asid_i(ireq_asid_i),
      .dreq_valid_i(dreq_valid_i), .dreq_ready_o(dreq_ready_o),
      .dreq_vaddr_i(dreq_vaddr_i), .dreq_asid_i(dreq_asid_i),
      .rsp_valid_o(rsp_valid_o), .rsp_src_o(rsp_src_o), .rsp_hit_o(rsp_hit_o),
      .rsp_content_o(rsp_content_o), .rsp_is_4M_o(rsp_is_4M_o),
      .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o), .upd_data_i(upd_data_i),
      .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
      .flush_asid_i(flush_asid_i), .flush_vaddr_i(flush_vaddr_i),
      .tlb_lu_access_o(tlb_lu_access_o), .tlb_lu_asid_o(tlb_lu_asid_o),
      .tlb_lu_vaddr_o(tlb_lu_vaddr_o), .tlb_lu_hit_i(tlb_lu_hit_i),
      .tlb_lu_content_i(tlb_lu_content_i), .tlb_lu_is_4M_i(tlb_lu_is_4M_i),
      .tlb_update_o(tlb_update_o), .tlb_flush_o(tlb_flush_o),
      .tlb_asid_to_be_flushed_o(tlb_asid_to_be_flushed_o),
      .tlb_vaddr_to_be_flushed_o(tlb_vaddr_to_be_flushed_o),
      .miss_cnt_o(miss_cnt_o)
   );

   // Fake one-entry TLB. Fill word: [43] valid, [42] 4M, [41:32] tag, [31:0] content.
   logic        tb_valid = 1'b0, tb_4m = 1'b0;
   logic [9:0]  tb_tag = 10'd0;
   logic [31:0] tb_content = 32'd0;
   assign tlb_lu_hit_i     = tb_valid && (tlb_lu_vaddr_o[31:22] == tb_tag);
   assign tlb_lu_content_i = tb_content;
   assign tlb_lu_is_4M_i   = tb_4m;
   always @(posedge clk)
      if (tlb_update_o[62]) begin
         tb_valid   <= tlb_update_o[43];
         tb_4m      <= tlb_update_o[42];
         tb_tag     <= tlb_update_o[41:32];
         tb_content <= tlb_update_o[31:0];
      end

   // Reference model
   int          m_block = 0;          // cycles of blocked traffic left after a flush accept
   logic        m_prefer_i = 1'b1;    // I wins the next tie
   logic [0:0]  m_fas = 0;
   logic [31:0] m_fva = 0;
   logic        m_rv = 0, m_rsrc = 0, m_rhit = 0, m_r4m = 0;
   logic [31:0] m_rcont = 0;
   int unsigned m_miss = 0;
   logic        m_valid = 0, m_4m = 0;
   logic [9:0]  m_tag = 0;
   logic [31:0] m_content = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic iv, input logic [31:0] ia, input logic [0:0] ias,
                       input logic dv, input logic [31:0] da, input logic [0:0] das,
                       input logic uv, input logic [62:0] ud,
                       input logic fv, input logic [0:0] fas, input logic [31:0] fa);
      logic free, facc, gi, gd, hit;
      logic [31:0] va;
      ireq_valid_i = iv; ireq_vaddr_i = ia; ireq_asid_i = ias;
      dreq_valid_i = dv; dreq_vaddr_i = da; dreq_asid_i = das;
      upd_valid_i = uv; upd_data_i = ud;
      flush_valid_i = fv; flush_asid_i = fas; flush_vaddr_i = fa;
      #1;
      free = (m_block == 0) && !fv;
      facc = (m_block == 0) && fv;
      gi   = free && iv && (!dv || m_prefer_i);
      gd   = free && dv && (!iv || !m_prefer_i);
      va   = gi ? ia : (gd ? da : 32'd0);
      chk("flush_ready", 64'(flush_ready_o), 64'(facc));
      chk("upd_ready", 64'(upd_ready_o), 64'(free));
      chk("ireq_ready", 64'(ireq_ready_o), 64'(gi));
      chk("dreq_ready", 64'(dreq_ready_o), 64'(gd));
      chk("lu_access", 64'(tlb_lu_access_o), 64'(gi || gd));
      chk("lu_vaddr", 64'(tlb_lu_vaddr_o), 64'(va));
      chk("lu_asid", 64'(tlb_lu_asid_o), 64'(gi ? ias : (gd ? das : 1'b0)));
      chk("tlb_update", 64'(tlb_update_o), free ? 64'({uv, ud[61:0]}) : 64'd0);
      chk("tlb_flush", 64'(tlb_flush_o), 64'(m_block == 2));
      chk("flush_vaddr", 64'(tlb_vaddr_to_be_flushed_o), (m_block == 2) ? 64'(m_fva) : 64'd0);
      chk("flush_asid", 64'(tlb_asid_to_be_flushed_o), (m_block == 2) ? 64'(m_fas) : 64'd0);
      chk("rsp_valid", 64'(rsp_valid_o), 64'(m_rv));
      chk("rsp_src", 64'(rsp_src_o), 64'(m_rsrc));
      chk("rsp_hit", 64'(rsp_hit_o), 64'(m_rhit));
      chk("rsp_content", 64'(rsp_content_o), 64'(m_rcont));
      chk("rsp_is_4M", 64'(rsp_is_4M_o), 64'(m_r4m));
      chk("miss_cnt", 64'(miss_cnt_o), 64'(m_miss % 65536));
      hit = m_valid && (va[31:22] == m_tag);
      @(posedge clk);
      if (m_rv && !m_rhit) m_miss++;
      m_rv = gi || gd;
      if (gi || gd) begin
         m_rsrc = gd; m_rhit = hit;
         m_rcont = hit ? m_content : 32'd0;
         m_r4m = hit && m_4m;
         m_prefer_i = gd;
      end
      if (facc) begin m_block = 2; m_fva = fa; m_fas = fas; end
      else if (m_block > 0) m_block--;
      if (free && uv) begin
         m_valid = ud[43]; m_4m = ud[42]; m_tag = ud[41:32]; m_content = ud[31:0];
      end
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input logic iv, input logic [31:0] ia);
      rst_i = 1'b1;
      ireq_valid_i = iv; ireq_vaddr_i = ia; dreq_valid_i = 0;
      upd_valid_i = 0; flush_valid_i = 0;
      @(posedge clk);
      #1;
      rst_i = 1'b0;
      m_block = 0; m_prefer_i = 1'b1; m_fva = 0; m_fas = 0;
      m_rv = 0; m_rsrc = 0; m_rhit = 0; m_rcont = 0; m_r4m = 0; m_miss = 0;
   endtask

   function automatic logic [62:0] fill(input logic v, input logic m4, input logic [9:0] tag,
                                        input logic [31:0] c);
      return {19'($urandom), v, m4, tag, c};
   endfunction

   initial begin
      logic [62:0] ud;
      logic [9:0]  tg;
      // Reset state
      do_reset(0, 0);
      do_reset(0, 0);
      idle();
      // Install a valid entry and check I/D round-robin starting with I
      step(0, 0, 0, 0, 0, 0, 1, fill(1, 1, 10'h155, 32'hCAFE_0001), 0, 0, 0);
      step(1, 32'h5540_0000, 1, 1, 32'h1234_0000, 0, 0, 0, 0, 0, 0);
      step(1, 32'h5540_0000, 0, 1, 32'h5550_0000, 1, 0, 0, 0, 0, 0);
      step(1, 32'h0000_1000, 1, 1, 32'h5540_0000, 0, 0, 0, 0, 0, 0);
      idle();
      // Flush beats ireq and update; ireq granted in the third cycle after
      step(1, 32'h5540_0000, 0, 0, 0, 0, 1, fill(1, 0, 10'h3, 32'h1), 1, 1, 32'h0040_0000);
      step(1, 32'h5540_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 32'h5540_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 32'h5540_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      // Update with bit 62 clear plus dreq to the new tag: response is pre-update
      ud = fill(1, 1, 10'h0AB, 32'h0BAD_F00D);
      ud[62] = 1'b0;
      step(0, 0, 0, 1, 32'h2AC0_0000, 1, 1, ud, 0, 0, 0);
      step(0, 0, 0, 1, 32'h2AC0_0000, 0, 0, 0, 0, 0, 0);
      idle();
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         tg = ($urandom_range(0, 1) == 1) ? m_tag : 10'($urandom);
         step(1'($urandom), {tg, 22'($urandom)}, 1'($urandom),
              1'($urandom), {($urandom_range(0, 1) == 1) ? m_tag : 10'($urandom), 22'($urandom)},
              1'($urandom),
              ($urandom_range(0, 3) == 0), fill(1'($urandom), 1'($urandom), 10'($urandom), $urandom),
              ($urandom_range(0, 9) == 0), 1'($urandom), $urandom);
      end
      // Reset while in FLUSH abandons the flush
      idle(); idle(); idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0040_0000);
      do_reset(0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0080_0000);
      idle(); idle(); idle();
      // Lookup granted in the reset cycle is dropped
      do_reset(1, 32'h5540_0000);
      idle();
      // Miss counter wrap: invalidate entry, then 65536 missing lookups
      step(0, 0, 0, 0, 0, 0, 1, 63'd0, 0, 0, 0);
      do_reset(0, 0);
      for (int i = 0; i < 65536; i++)
         step(1, 32'h0000_1000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("miss_cnt_full", 64'(miss_cnt_o), 64'hFFFF);
      idle();
      chk("miss_cnt_wrap", 64'(miss_cnt_o), 64'h0000);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
